// File: rtl/ram_pkg.sv
// Shared types and helpers for the single-port RAM arbiter family.
package ram_pkg;

  localparam int NumReqMax = 8;
  localparam int PtrW      = 3;

  typedef enum logic {
    ARB_INIT = 1'b0,
    ARB_RUN  = 1'b1
  } arb_state_e;

  // Round-robin successor of idx among num requesters, wrapping to 0.
  function automatic logic [PtrW-1:0] rr_next_ptr(input logic [PtrW-1:0] idx,
                                                  input logic [PtrW:0]   num);
    logic [PtrW:0] nxt;
    nxt = {1'b0, idx} + {{PtrW{1'b0}}, 1'b1};
    if (nxt >= num) begin
      rr_next_ptr = {PtrW{1'b0}};
    end else begin
      rr_next_ptr = nxt[PtrW-1:0];
    end
  endfunction

endpackage

// File: rtl/ram_single.sv
// Single-port synchronous RAM with one-cycle registered read.
module ram_single #(
  parameter int Width = 32,
  parameter int Depth = 256,
  localparam int Aw   = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             we_i,
  input  logic             re_i,
  input  logic [Aw-1:0]    addr_i,
  input  logic [Width-1:0] wdata_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] rdata_q;

  // Storage array; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  // Read register, updated only on a read strobe.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, registered priority pointer.
module rr_arbiter
  import ram_pkg::*;
#(
  parameter int NumReq = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic [NumReq-1:0] req_i,
  output logic [NumReq-1:0] gnt_o,
  output logic [PtrW-1:0]   ptr_o
);

  logic [PtrW-1:0]   ptr_q, ptr_d;
  logic [NumReq-1:0] gnt_s;
  logic [PtrW-1:0]   win_s;
  logic              found_s;

  // Scan from ptr upward, then wrap to indices below ptr.
  always_comb begin
    gnt_s   = '0;
    win_s   = '0;
    found_s = 1'b0;
    for (int k = 0; k < NumReq; k++) begin
      if (en_i && !found_s && req_i[k] && (k >= int'(ptr_q))) begin
        found_s  = 1'b1;
        win_s    = PtrW'(k);
        gnt_s[k] = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
    for (int k = 0; k < NumReq; k++) begin
      if (en_i && !found_s && req_i[k] && (k < int'(ptr_q))) begin
        found_s  = 1'b1;
        win_s    = PtrW'(k);
        gnt_s[k] = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
    if (found_s) begin
      ptr_d = rr_next_ptr(win_s, (PtrW + 1)'(NumReq));
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Priority pointer register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign gnt_o = gnt_s;
  assign ptr_o = ptr_q;

endmodule

// File: rtl/ram_single_arb.sv
// Round-robin sharing of one ram_single among NumReq requesters.
// Define RAM_ARB_INIT_EN to zero the RAM with an INIT sweep after reset.
module ram_single_arb
  import ram_pkg::*;
#(
  parameter int Width  = 32,
  parameter int Depth  = 256,
  parameter int NumReq = 2,
  localparam int Aw    = $clog2(Depth)
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NumReq-1:0]              req_i,
  input  logic [NumReq-1:0]              we_i,
  input  logic [NumReq-1:0][Aw-1:0]      addr_i,
  input  logic [NumReq-1:0][Width-1:0]   wdata_i,
  output logic [NumReq-1:0]              gnt_o,
  output logic [NumReq-1:0]              rvalid_o,
  output logic [Width-1:0]               rdata_o,
  output logic                           busy_o
);

  logic              run_s;
  logic              init_s;
  logic [Aw-1:0]     init_addr_s;
  logic              en_s;
  logic [NumReq-1:0] gnt_s;
  logic [NumReq-1:0] rvalid_q, rvalid_d;
  logic              ram_we_s, ram_re_s;
  logic [Aw-1:0]     ram_addr_s;
  logic [Width-1:0]  ram_wdata_s;
  logic [Width-1:0]  ram_rdata_s;

`ifdef RAM_ARB_INIT_EN
  arb_state_e    state_q, state_d;
  logic [Aw-1:0] cnt_q, cnt_d;

  // INIT sweeps every address once, then hands over to RUN for good.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ARB_INIT: begin
        cnt_d = cnt_q + Aw'(1);
        if (cnt_q == Aw'(Depth - 1)) begin
          state_d = ARB_RUN;
        end else begin
          state_d = ARB_INIT;
        end
      end
      ARB_RUN: begin
        state_d = ARB_RUN;
      end
      default: begin
        state_d = ARB_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  // Init FSM state and sweep counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ARB_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign run_s       = (state_q == ARB_RUN);
  assign init_s      = (state_q == ARB_INIT);
  assign init_addr_s = cnt_q;
  assign busy_o      = init_s;
`else
  assign run_s       = 1'b1;
  assign init_s      = 1'b0;
  assign init_addr_s = '0;
  assign busy_o      = 1'b0;
`endif

  // Gating with rst_ni keeps gnt_o low while reset is held.
  assign en_s = run_s & rst_ni;

  rr_arbiter #(
    .NumReq (NumReq)
  ) u_arb (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (en_s),
    .req_i  (req_i),
    .gnt_o  (gnt_s),
    .ptr_o  ()
  );

  // RAM port mux: init sweep, else the granted requester, else idle.
  always_comb begin
    ram_we_s    = 1'b0;
    ram_re_s    = 1'b0;
    ram_addr_s  = '0;
    ram_wdata_s = '0;
    if (init_s) begin
      ram_we_s   = 1'b1;
      ram_addr_s = init_addr_s;
    end else begin
      for (int k = 0; k < NumReq; k++) begin
        if (gnt_s[k]) begin
          ram_we_s    = we_i[k];
          ram_re_s    = ~we_i[k];
          ram_addr_s  = addr_i[k];
          ram_wdata_s = wdata_i[k];
        end else begin
          ram_we_s = ram_we_s;
        end
      end
    end
  end

  assign rvalid_d = gnt_s & ~we_i;

  // Read-owner tag, aligned with the RAM's registered read data.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= '0;
    end else begin
      rvalid_q <= rvalid_d;
    end
  end

  ram_single #(
    .Width (Width),
    .Depth (Depth)
  ) u_ram (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .we_i    (ram_we_s),
    .re_i    (ram_re_s),
    .addr_i  (ram_addr_s),
    .wdata_i (ram_wdata_s),
    .rdata_o (ram_rdata_s)
  );

  assign gnt_o    = gnt_s;
  assign rvalid_o = rvalid_q;
  assign rdata_o  = (|rvalid_q) ? ram_rdata_s : '0;

endmodule

// File: tb/tb_ram_single_arb.sv
// Directed and randomized bench for ram_single_arb (default build, NumReq=2).
module tb_ram_single_arb;

  localparam int W  = 32;
  localparam int D  = 256;
  localparam int N  = 2;
  localparam int AW = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req, we;
  logic [N-1:0][AW-1:0] addr;
  logic [N-1:0][W-1:0]  wdata;
  logic [N-1:0]      gnt, rvalid;
  logic [W-1:0]      rdata;
  logic              busy;

  ram_single_arb #(.Width(W), .Depth(D), .NumReq(N)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata), .busy_o(busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  logic [W-1:0] mdl_mem [D];
  int           mdl_ptr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at negedge, check grant, then check read response.
  task automatic step(input logic [N-1:0] r, input logic [N-1:0] w,
                      input int a0, input int a1,
                      input logic [W-1:0] d0, input logic [W-1:0] d1,
                      output int granted);
    logic [N-1:0] exp_rv;
    logic [W-1:0] exp_rd;
    req = r; we = w;
    addr[0] = AW'(a0); addr[1] = AW'(a1);
    wdata[0] = d0; wdata[1] = d1;
    #1;
    granted = -1;
    for (int i = 0; i < N; i++) begin
      if (granted < 0 && r[(mdl_ptr + i) % N]) granted = (mdl_ptr + i) % N;
    end
    chk("gnt", 64'(gnt), (granted < 0) ? 64'd0 : (64'd1 << granted));
    chk("busy", 64'(busy), 64'd0);
    @(posedge clk);
    exp_rv = '0;
    exp_rd = '0;
    if (granted >= 0) begin
      mdl_ptr = (granted + 1) % N;
      if (w[granted]) mdl_mem[addr[granted]] = wdata[granted];
      else begin
        exp_rv[granted] = 1'b1;
        exp_rd = mdl_mem[addr[granted]];
      end
    end
    #1;
    chk("rvalid", 64'(rvalid), 64'(exp_rv));
    chk("rdata", 64'(rdata), 64'(exp_rd));
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_rvalid", 64'(rvalid), 64'd0);
    chk("rst_rdata", 64'(rdata), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    mdl_ptr = 0;
  endtask

  initial begin
    int g;
    logic [N-1:0] pr, pw;
    int pa [N];
    logic [W-1:0] pd [N];

    req = '1; we = '0; addr = '0; wdata = '0; rst_n = 1'b1;
    @(negedge clk);
    do_reset();

    // Prefill addresses 0..16 through requester 0.
    for (int a = 0; a <= 16; a++) begin
      step(2'b01, 2'b01, a, 0, $urandom, 32'd0, g);
    end

    // Single read: write 0x10 via req0, read it back via req1.
    step(2'b01, 2'b01, 16, 0, 32'hDEADBEEF, 32'd0, g);
    step(2'b10, 2'b00, 0, 16, 32'd0, 32'd0, g);
    chk("single_read_gnt", 64'(g), 64'd1);
    chk("single_read_data", 64'(mdl_mem[16]), 64'hDEADBEEF);

    // Contention from reset: strict alternation starting at requester 0.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(2'b11, 2'b00, $urandom_range(0, 16), $urandom_range(0, 16), 32'd0, 32'd0, g);
      chk("contention_order", 64'(g), 64'(i % 2));
    end

    // Fairness: req1 pulsed at cycle 3 wins immediately.
    for (int i = 0; i < 8; i++) begin
      step((i == 3) ? 2'b11 : 2'b01, 2'b00, $urandom_range(0, 16), $urandom_range(0, 16),
           32'd0, 32'd0, g);
      chk("fairness", 64'(g), (i == 3) ? 64'd1 : 64'd0);
    end

    // Idle: nothing granted, pointer held (probed by the contended step after).
    for (int i = 0; i < 10; i++) step(2'b00, 2'b00, 0, 0, 32'd0, 32'd0, g);
    step(2'b11, 2'b00, 1, 2, 32'd0, 32'd0, g);
    chk("idle_ptr_hold", 64'(g), 64'd1);

    // Reset mid-read: drop pending rvalid, pointer returns to 0.
    step(2'b01, 2'b00, 5, 0, 32'd0, 32'd0, g);
    step(2'b01, 2'b00, 5, 0, 32'd0, 32'd0, g);
    req = '0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_rvalid", 64'(rvalid), 64'd0);
    chk("midrst_rdata", 64'(rdata), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mdl_ptr = 0;
    step(2'b11, 2'b00, 3, 4, 32'd0, 32'd0, g);
    chk("midrst_ptr0", 64'(g), 64'd0);

    // Randomized traffic honouring hold-until-grant.
    pr = '0; pw = '0;
    for (int k = 0; k < N; k++) begin pa[k] = 0; pd[k] = '0; end
    for (int i = 0; i < 300; i++) begin
      for (int k = 0; k < N; k++) begin
        if (!pr[k]) begin
          pr[k] = ($urandom_range(0, 3) != 0);
          pw[k] = $urandom_range(0, 1) == 1;
          pa[k] = $urandom_range(0, 16);
          pd[k] = $urandom;
        end
      end
      step(pr, pw, pa[0], pa[1], pd[0], pd[1], g);
      if (g >= 0) pr[g] = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
